apb_fnd_scan_n: RTL and testbench

APB slave peripheral that drives an N-digit multiplexed common-anode 7-segment display. It is the parametrised successor of the 4-digit FND counter peripheral and sits on the same APB bus. It adds a configurable digit count, a hex/decimal display mode, sequential binary-to-BCD conversion, leading-zero blanking, blink, overflow indication and tear-free display updates.

---
 rtl/apb_fnd_scan_n.sv | 259 +++++++++++++++++++++++++
 tb/tb_apb_fnd_scan_n.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fnd_scan_n.sv
// APB peripheral driving an N-digit multiplexed common-anode 7-segment display,
// with hex/decimal modes, sequential BCD conversion, blanking, blink and overflow.
module apb_fnd_scan_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [3:0]            PADDR,
    input  logic [31:0]           PWDATA,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic [NUM_DIGITS-1:0] fnd_comm,
    output logic [7:0]            fnd_font
);

    localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int PRE_W    = $clog2(SCAN_DIV);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int SH_W     = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEX_LOAD,
        S_SHIFT,
        S_FINISH
    } conv_state_e;

    function automatic logic [7:0] seg_font(input logic [3:0] n);
        logic [7:0] f;
        case (n)
            4'h0: f = 8'hC0;
            4'h1: f = 8'hF9;
            4'h2: f = 8'hA4;
            4'h3: f = 8'hB0;
            4'h4: f = 8'h99;
            4'h5: f = 8'h92;
            4'h6: f = 8'h82;
            4'h7: f = 8'hF8;
            4'h8: f = 8'h80;
            4'h9: f = 8'h90;
            4'hA: f = 8'h88;
            4'hB: f = 8'h83;
            4'hC: f = 8'hC6;
            4'hD: f = 8'hA1;
            4'hE: f = 8'h86;
            default: f = 8'h8E;
        endcase
        return f;
    endfunction

    logic [3:0]            cr_q, cr_d;
    logic [31:0]           dr_q, dr_d;
    logic [NUM_DIGITS-1:0] dpr_q, dpr_d;
    logic                  pready_q, pready_d;
    logic [31:0]           prdata_q, prdata_d;
    conv_state_e           state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [31:0]           bin_q, bin_d;
    logic [39:0]           bcd_q, bcd_d;
    logic [SH_W-1:0]       shadow_q, shadow_d;
    logic                  ovf_q, ovf_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  blink_off_q, blink_off_d;
    logic [NUM_DIGITS-1:0] comm_q, comm_d;
    logic [7:0]            font_q, font_d;

    logic        access, busy, trigger, trig_hex, tick;
    logic [31:0] trig_val;
    logic [39:0] bcd_adj;
    logic        unused_paddr;

    assign access       = PSEL & PENABLE & ~pready_q;
    assign busy         = (state_q == S_SHIFT) || (state_q == S_FINISH);
    assign unused_paddr = ^PADDR[1:0];

    // A conversion is (re)started by any DR write or a CR write that flips HEX.
    always_comb begin
        cr_d     = cr_q;
        dr_d     = dr_q;
        dpr_d    = dpr_q;
        prdata_d = prdata_q;
        pready_d = access;
        trigger  = 1'b0;
        trig_hex = cr_q[1];
        trig_val = dr_q;
        if (access && PWRITE) begin
            case (PADDR[3:2])
                2'd0: begin
                    cr_d = PWDATA[3:0];
                    if (PWDATA[1] != cr_q[1]) begin
                        trigger  = 1'b1;
                        trig_hex = PWDATA[1];
                    end
                end
                2'd1: begin
                    dr_d     = PWDATA;
                    trigger  = 1'b1;
                    trig_val = PWDATA;
                end
                2'd2:    dpr_d = PWDATA[NUM_DIGITS-1:0];
                default: ;
            endcase
        end else if (access) begin
            case (PADDR[3:2])
                2'd0:    prdata_d = {28'd0, cr_q};
                2'd1:    prdata_d = dr_q;
                2'd2:    prdata_d = 32'(dpr_q);
                default: prdata_d = {30'd0, ovf_q, busy};
            endcase
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < 10; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Shadow only ever loads from a finished conversion or a hex load, never mid-shift.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        if (trigger) begin
            if (trig_hex) begin
                state_d = S_HEX_LOAD;
            end else begin
                state_d = S_SHIFT;
                cnt_d   = 5'd0;
                bin_d   = trig_val;
                bcd_d   = 40'd0;
            end
        end else begin
            case (state_q)
                S_HEX_LOAD: begin
                    shadow_d = dr_q[SH_W-1:0];
                    ovf_d    = 1'b0;
                    state_d  = S_IDLE;
                end
                S_SHIFT: begin
                    bcd_d = {bcd_adj[38:0], bin_q[31]};
                    bin_d = {bin_q[30:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FINISH;
                end
                S_FINISH: begin
                    shadow_d = bcd_q[SH_W-1:0];
                    ovf_d    = |bcd_q[39:SH_W];
                    state_d  = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tick        = (presc_q == PRE_W'(SCAN_DIV - 1));
        presc_d     = tick ? '0 : presc_q + PRE_W'(1);
        idx_d       = idx_q;
        blk_cnt_d   = blk_cnt_q;
        blink_off_d = blink_off_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            if (blk_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blk_cnt_d   = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    logic [3:0]       digit;
    logic             dot, blank, disp_on;
    logic [IDX_W-1:0] top;
    logic [7:0]       glyph;

    always_comb begin
        digit = 4'd0;
        dot   = 1'b0;
        top   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit = shadow_q[4*i +: 4];
                dot   = dpr_q[i];
            end
            if (shadow_q[4*i +: 4] != 4'd0) top = IDX_W'(i);
        end
        blank   = cr_q[2] && (idx_q > top);
        disp_on = cr_q[0] && !(cr_q[3] && blink_off_q);
        glyph   = seg_font(digit);
        if (dot) glyph[7] = 1'b0;
        if (ovf_q && !cr_q[1]) glyph = 8'hBF;
        else if (blank)        glyph = 8'hFF;
        comm_d = disp_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        font_d = disp_on ? glyph : 8'hFF;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cr_q        <= '0;
            dr_q        <= '0;
            dpr_q       <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            shadow_q    <= '0;
            ovf_q       <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            blk_cnt_q   <= '0;
            blink_off_q <= 1'b0;
            comm_q      <= '1;
            font_q      <= 8'hFF;
        end else begin
            cr_q        <= cr_d;
            dr_q        <= dr_d;
            dpr_q       <= dpr_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            shadow_q    <= shadow_d;
            ovf_q       <= ovf_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blk_cnt_q   <= blk_cnt_d;
            blink_off_q <= blink_off_d;
            comm_q      <= comm_d;
            font_q      <= font_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign fnd_comm = comm_q;
    assign fnd_font = font_q;

endmodule

// File: tb/tb_apb_fnd_scan_n.sv
// Self-checking bench for apb_fnd_scan_n: APB protocol, register map, conversion
// timing and the scanned display compared against an arithmetic display model.
module tb_apb_fnd_scan_n;

    localparam int N   = 4;
    localparam int CLK = 1000;
    localparam int SHZ = 100;
    localparam int BT  = 2;
    localparam int DIV = CLK / SHZ;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic [3:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [N-1:0] fnd_comm;
    logic [7:0]  fnd_font;

    apb_fnd_scan_n #(
        .NUM_DIGITS(N), .CLK_FREQ_HZ(CLK), .SCAN_HZ(SHZ), .BLINK_TICKS(BT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .fnd_comm(fnd_comm), .fnd_font(fnd_font)
    );

    always #5 PCLK = ~PCLK;

    // Edges since reset release; drives the scan/blink timing model.
    int cyc;
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] font_tab [16];
    bit              m_en, m_hex, m_lzb, m_blink;
    logic [3:0]      m_dpr;
    longint unsigned m_val;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned p10(input int e);
        longint unsigned r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int dig(input int i);
        if (m_hex) return int'((m_val >> (4 * i)) & 64'hF);
        return int'((m_val / p10(i)) % 10);
    endfunction

    function automatic bit model_ovf();
        return !m_hex && (m_val >= p10(N));
    endfunction

    function automatic bit disp_on(input int k);
        int t = (k - 1) / DIV;
        return m_en && !(m_blink && ((t / BT) % 2 == 1));
    endfunction

    function automatic logic [3:0] exp_comm(input int k);
        int idx = ((k - 1) / DIV) % N;
        if (!disp_on(k)) return 4'hF;
        return ~(4'(1) << idx);
    endfunction

    function automatic logic [7:0] exp_font(input int k);
        int idx = ((k - 1) / DIV) % N;
        int top = 0;
        logic [7:0] g;
        for (int i = 0; i < N; i++) if (dig(i) != 0) top = i;
        if (model_ovf()) return 8'hBF;
        if (m_lzb && idx > top) return 8'hFF;
        g = font_tab[dig(idx)];
        if (m_dpr[idx]) g = g & 8'h7F;
        return g;
    endfunction

    task automatic wait_until(input int target);
        for (int i = 0; i < 100000 && cyc < target; i++) @(negedge PCLK);
    endtask

    // One APB transfer: setup, one wait cycle, PREADY pulse, idle.
    task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output int commit);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        checkOutput("pready_wait", PREADY, 1'b0);
        @(negedge PCLK);
        checkOutput("pready_high", PREADY, 1'b1);
        rdata  = PRDATA;
        commit = cyc;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        checkOutput("pready_single", PREADY, 1'b0);
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data, output int commit);
        logic [31:0] rd;
        apb(1'b1, addr, data, rd, commit);
        if (addr == 4'h0) begin
            m_en = data[0]; m_hex = data[1]; m_lzb = data[2]; m_blink = data[3];
        end
        if (addr == 4'h8) m_dpr = data[3:0];
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int c;
        apb(1'b0, addr, 32'd0, rd, c);
        checkOutput(tag, rd, exp);
    endtask

    task automatic check_now(input string tag);
        checkOutput({tag, "_comm"}, fnd_comm, exp_comm(cyc));
        if (disp_on(cyc)) checkOutput({tag, "_font"}, fnd_font, exp_font(cyc));
    endtask

    task automatic check_display(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            check_now(tag);
        end
    endtask

    task automatic applyStimulus(input int iter);
        int e;
        logic [31:0] cr, val;
        int kind = $urandom_range(0, 2);
        cr  = {28'd0, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, 1'b0, 2'b00};
        cr  = {28'd0, 1'b0, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0)};
        val = (kind == 0) ? $urandom_range(0, 99) :
              (kind == 1) ? $urandom_range(0, 9999) : $urandom;
        write_reg(4'h0, cr, e);
        write_reg(4'h8, {28'd0, 4'($urandom)}, e);
        write_reg(4'h4, val, e);
        m_val = val;
        wait_until(e + 36);
        read_check($sformatf("rand%0d_sr", iter), 4'hC, {30'd0, model_ovf(), 1'b0});
        check_display($sformatf("rand%0d", iter), 40);
    endtask

    initial begin
        int e, e2;
        bit seen_nine;
        logic [31:0] rd;
        font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                     8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        m_en = 0; m_hex = 0; m_lzb = 0; m_blink = 0; m_dpr = 0; m_val = 0;

        #2 PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        checkOutput("rst_comm", fnd_comm, 4'hF);
        checkOutput("rst_font", fnd_font, 8'hFF);
        checkOutput("rst_pready", PREADY, 1'b0);
        checkOutput("rst_prdata", PRDATA, 32'd0);
        PRESETn = 1'b1;
        read_check("rst_cr", 4'h0, 32'd0);
        read_check("rst_dr", 4'h4, 32'd0);
        read_check("rst_dpr", 4'h8, 32'd0);
        read_check("rst_sr", 4'hC, 32'd0);
        check_display("rst_disp", 10);

        // Decimal 1234: BUSY still high when read commits at E+33.
        write_reg(4'h0, 32'h1, e);
        write_reg(4'h4, 32'd1234, e);
        wait_until(e + 30);
        read_check("dec_busy", 4'hC, 32'h1);
        m_val = 1234;
        wait_until(e + 36);
        read_check("dec_idle", 4'hC, 32'h0);
        read_check("dec_dr", 4'h4, 32'd1234);
        check_display("dec1234", 45);

        // Hex 0xBEEF with a dot on digit 1; shadow follows one cycle after commit.
        write_reg(4'h0, 32'h3, e);
        write_reg(4'h8, 32'h2, e);
        write_reg(4'h4, 32'h0, e);
        m_val = 0;
        wait_until(e + 5);
        write_reg(4'h4, 32'hBEEF, e);
        check_now("hex_old");
        m_val = 32'hBEEF;
        @(negedge PCLK);
        check_now("hex_new");
        read_check("hex_dpr", 4'h8, 32'h2);
        check_display("hexbeef", 40);

        // Decimal with leading-zero blanking, then overflow.
        write_reg(4'h0, 32'h5, e);
        write_reg(4'h4, 32'd7, e);
        m_val = 7;
        wait_until(e + 36);
        check_display("lzb7", 40);
        write_reg(4'h4, 32'd10000, e);
        m_val = 10000;
        wait_until(e + 36);
        read_check("ovf_sr", 4'hC, 32'h2);
        check_display("ovf", 40);

        // Abort: 9999 is replaced by 42 ten cycles later and must never be displayed.
        write_reg(4'h0, 32'h1, e);
        write_reg(4'h8, 32'h0, e);
        write_reg(4'h4, 32'd0, e);
        m_val = 0;
        wait_until(e + 36);
        write_reg(4'h4, 32'd9999, e);
        wait_until(e + 7);
        write_reg(4'h4, 32'd42, e2);
        checkOutput("abort_spacing", 64'(e2 - e), 64'd10);
        seen_nine = 1'b0;
        while (cyc < e2 + 31) begin
            @(negedge PCLK);
            if ((fnd_font & 8'h7F) == 8'h10) seen_nine = 1'b1;
        end
        read_check("abort_busy_fall", 4'hC, 32'h0);
        m_val = 42;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if ((fnd_font & 8'h7F) == 8'h10) seen_nine = 1'b1;
            check_now("abort42");
        end
        checkOutput("abort_no_9999", seen_nine, 1'b0);

        // Blink: display alternates on/off every BLINK_TICKS scan ticks.
        write_reg(4'h4, 32'd1234, e);
        m_val = 1234;
        wait_until(e + 36);
        write_reg(4'h0, 32'h9, e);
        check_display("blink", 100);

        for (int i = 0; i < 6; i++) applyStimulus(i);

        // Reset in the middle of a conversion.
        write_reg(4'h0, 32'h1, e);
        write_reg(4'h4, 32'd5555, e);
        read_check("pre_rst_dr", 4'h4, 32'd5555);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        checkOutput("midrst_comm", fnd_comm, 4'hF);
        checkOutput("midrst_font", fnd_font, 8'hFF);
        checkOutput("midrst_prdata", PRDATA, 32'd0);
        checkOutput("midrst_pready", PREADY, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        m_en = 0; m_hex = 0; m_lzb = 0; m_blink = 0; m_dpr = 0; m_val = 0;
        read_check("midrst_sr", 4'hC, 32'd0);
        read_check("midrst_cr", 4'h0, 32'd0);
        read_check("midrst_dr", 4'h4, 32'd0);
        check_display("midrst_disp", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
